// File: rtl/spi_reg_ctrl_if.sv
// Byte-stream link between spi_slave and the register controller.
// The master side is spi_slave (or a bench model of it); the slave side is spi_reg_ctrl.
interface spi_reg_ctrl_if;
  logic       ss;
  logic       rx_done;
  logic [7:0] rx_byte;
  logic [7:0] tx_byte;

  modport master (
    output ss,
    output rx_done,
    output rx_byte,
    input  tx_byte
  );

  modport slave (
    input  ss,
    input  rx_done,
    input  rx_byte,
    output tx_byte
  );
endinterface

// File: rtl/spi_reg_ctrl.sv
// SPI register-access controller.
// The first byte of each SS-low frame is a command: bit7 = read, bits[6:0] = start address.
// The following bytes are write data, or read turnaround/data, with the address auto-incrementing.
// The block holds the RW config registers and exposes the RO status inputs.
module spi_reg_ctrl #(
  parameter int unsigned NUM_CFG  = 16,
  parameter int unsigned NUM_STAT = 4,
  parameter logic [7:0]  ID_BYTE  = 8'hA5,
  parameter logic [7:0]  CFG_RST  = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst,
  spi_reg_ctrl_if.slave         bus,
  output logic [8*NUM_CFG-1:0]  cfg_out,
  input  logic [8*NUM_STAT-1:0] stat_in,
  output logic                  wr_stb,
  output logic [6:0]            wr_addr,
  output logic                  busy,
  output logic                  txn_done
);

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    WRITE,
    READ
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       ss_meta;
  logic       ss_s;
  logic [6:0] ptr;
  logic [6:0] ptr_nxt;
  logic [6:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] tx_nxt;
  logic       cmd_seen;
  logic       cmd_seen_nxt;
  logic       wr_en;
  logic       txn_nxt;
  logic       ptr_in_cfg;

  assign busy       = (state != IDLE);
  assign ptr_in_cfg = ({1'b0, ptr} < 8'(NUM_CFG));

  // Two-flop synchroniser for slave select. It idles deasserted (high).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ss_meta <= 1'b1;
      ss_s    <= 1'b1;
    end else begin
      ss_meta <= bus.ss;
      ss_s    <= ss_meta;
    end
  end

  // Read address: the command byte's address when in CMD, otherwise the next sequential address.
  always_comb begin
    rd_addr = (state == CMD) ? bus.rx_byte[6:0] : ptr + 7'd1;
  end

  // Register read mux: config registers, then status inputs, and zero above the mapped range.
  always_comb begin
    rd_data = 8'h00;
    for (int unsigned k = 0; k < NUM_CFG; k++) begin
      if (rd_addr == 7'(k)) rd_data = cfg_out[8*k +: 8];
    end
    for (int unsigned k = 0; k < NUM_STAT; k++) begin
      if (rd_addr == 7'(NUM_CFG + k)) rd_data = stat_in[8*k +: 8];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and datapath decode. The frame-end override comes last, so a byte that
  // arrives in the same cycle as the ss rise is still processed before returning to IDLE.
  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    tx_nxt       = bus.tx_byte;
    cmd_seen_nxt = cmd_seen;
    wr_en        = 1'b0;
    txn_nxt      = 1'b0;

    case (state)
      IDLE: begin
        tx_nxt = ID_BYTE;
        if (!ss_s) state_nxt = CMD;
      end
      CMD: begin
        if (bus.rx_done) begin
          ptr_nxt      = bus.rx_byte[6:0];
          cmd_seen_nxt = 1'b1;
          if (bus.rx_byte[7]) begin
            state_nxt = READ;
            tx_nxt    = rd_data;
          end else begin
            state_nxt = WRITE;
          end
        end
      end
      WRITE: begin
        if (bus.rx_done) begin
          wr_en   = ptr_in_cfg;
          ptr_nxt = ptr + 7'd1;
        end
      end
      READ: begin
        if (bus.rx_done) begin
          tx_nxt  = rd_data;
          ptr_nxt = ptr + 7'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Using cmd_seen_nxt means a command byte that coincides with the ss rise still counts.
    if ((state != IDLE) && ss_s) begin
      state_nxt    = IDLE;
      tx_nxt       = ID_BYTE;
      txn_nxt      = cmd_seen_nxt;
      cmd_seen_nxt = 1'b0;
    end
  end

  // Pointer, MISO byte and event strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr         <= '0;
      cmd_seen    <= 1'b0;
      bus.tx_byte <= ID_BYTE;
      wr_stb      <= 1'b0;
      wr_addr     <= '0;
      txn_done    <= 1'b0;
    end else begin
      ptr         <= ptr_nxt;
      cmd_seen    <= cmd_seen_nxt;
      bus.tx_byte <= tx_nxt;
      wr_stb      <= wr_en;
      if (wr_en) wr_addr <= ptr;
      txn_done    <= txn_nxt;
    end
  end

  // Config register file, written one byte at a time from the SPI stream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_out <= {NUM_CFG{CFG_RST}};
    end else if (wr_en) begin
      for (int unsigned k = 0; k < NUM_CFG; k++) begin
        if (ptr == 7'(k)) cfg_out[8*k +: 8] <= bus.rx_byte;
      end
    end
  end

endmodule
